nubus_vram_arbiter: RTL

- Sole owner of the SDRAM VRAM port of the NuBus video card.
- Shares the port between two requesters:
  - the CPU slot side: single-word reads and writes;
  - the scanline fetcher: sequential prefetch into an internal FIFO, drained at pixel rate.
- Arbitration is urgency-based with a starvation bound for the CPU; out-of-range addresses are handled without touching SDRAM.

---
 rtl/nubus_vram_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/nubus_vram_arbiter.sv
// nubus_vram_arbiter: sole owner of the SDRAM VRAM port of the NuBus video card.
// Shares the port between CPU single-word accesses and a scanline prefetcher
// that fills a show-ahead FIFO drained at pixel rate.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack              CPU read data and one-cycle completion
//   vid_start/base/len              start a line fetch (flushes the FIFO)
//   vid_pop, vid_data, vid_empty    FIFO consumer side (show-ahead head)
//   vid_done, vid_underflow         line fully fetched; sticky pop-on-empty
//   mem_addr/dout/din/rd/wr/ready   SDRAM controller handshake
module nubus_vram_arbiter #(
    parameter int unsigned VRAM_WORDS   = 153600,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned URGENT_LVL   = 4,
    parameter int unsigned CPU_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_start,
    input  logic [17:0] vid_base,
    input  logic [9:0]  vid_len,
    input  logic        vid_pop,
    output logic [15:0] vid_data,
    output logic        vid_empty,
    output logic        vid_done,
    output logic        vid_underflow,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ready
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned WaitW = $clog2(CPU_MAX_WAIT + 1);

    localparam logic [18:0]      VramLim  = 19'(VRAM_WORDS);
    localparam logic [LvlW-1:0]  DepthL   = LvlW'(FIFO_DEPTH);
    localparam logic [LvlW-1:0]  UrgentL  = LvlW'(URGENT_LVL);
    localparam logic [WaitW-1:0] MaxWaitL = WaitW'(CPU_MAX_WAIT);

    typedef enum logic [2:0] {StIdle, StCpuRd, StCpuWr, StVidRd, StCpuAck} state_e;

    state_e            state_q;
    logic [17:0]       mem_addr_q;
    logic [15:0]       mem_dout_q;
    logic              mem_rd_q, mem_wr_q;
    logic [15:0]       cpu_rdata_q;
    logic              cpu_ack_q;
    logic              cpu_oor_q;      // latched CPU access lies outside VRAM
    logic [WaitW-1:0]  cpu_wait_q;
    logic [17:0]       vid_ptr_q;
    logic [9:0]        vid_rem_q;
    logic              vid_busy_q;     // a video read is outstanding on SDRAM
    logic              vid_discard_q;  // outstanding video read belongs to a flushed line
    logic              underflow_q;
    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]   level_q;

    logic              vid_live, vid_want, vid_urgent, grant_vid, grant_cpu;
    logic              cpu_in_range, vid_in_range, mem_done, push, pop_ok;
    logic [15:0]       push_data;
    logic [LvlW-1:0]   level_resv;

    always_comb begin
        // A discarded read will never push, so it holds no FIFO reservation.
        vid_live     = vid_busy_q && !vid_discard_q;
        level_resv   = level_q + LvlW'(vid_live);
        cpu_in_range = {1'b0, cpu_addr} < VramLim;
        vid_in_range = {1'b0, vid_ptr_q} < VramLim;
        // Qualify with our own strobes so a stray ready after reset is ignored.
        mem_done     = mem_ready && (mem_rd_q || mem_wr_q);
        vid_want     = (vid_rem_q != '0) && (level_resv < DepthL) && !vid_start;
        vid_urgent   = vid_want && (level_q < UrgentL) && (cpu_wait_q < MaxWaitL);
        grant_vid    = (state_q == StIdle) && (vid_urgent || (vid_want && !cpu_req));
        grant_cpu    = (state_q == StIdle) && cpu_req && !vid_urgent;
        push         = 1'b0;
        push_data    = '0;
        if (grant_vid && !vid_in_range) begin
            push = 1'b1;  // out-of-range pixel: zero word, no SDRAM access
        end else if (state_q == StVidRd && mem_done && !vid_discard_q && !vid_start) begin
            push      = 1'b1;
            push_data = mem_din;
        end
        pop_ok       = vid_pop && (level_q != '0) && !vid_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            mem_addr_q    <= '0;
            mem_dout_q    <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_oor_q     <= 1'b0;
            cpu_wait_q    <= '0;
            vid_ptr_q     <= '0;
            vid_rem_q     <= '0;
            vid_busy_q    <= 1'b0;
            vid_discard_q <= 1'b0;
            underflow_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_vid) begin
                        vid_ptr_q <= vid_ptr_q + 18'd1;
                        vid_rem_q <= vid_rem_q - 10'd1;
                        if (cpu_req) begin
                            cpu_wait_q <= cpu_wait_q + WaitW'(1);
                        end
                        if (vid_in_range) begin
                            state_q    <= StVidRd;
                            mem_addr_q <= vid_ptr_q;
                            mem_rd_q   <= 1'b1;
                            vid_busy_q <= 1'b1;
                        end
                    end else if (grant_cpu) begin
                        cpu_wait_q <= '0;
                        mem_addr_q <= cpu_addr;
                        mem_dout_q <= cpu_wdata;
                        cpu_oor_q  <= !cpu_in_range;
                        mem_rd_q   <= cpu_in_range && !cpu_we;
                        mem_wr_q   <= cpu_in_range && cpu_we;
                        state_q    <= cpu_we ? StCpuWr : StCpuRd;
                    end
                end
                StCpuRd, StCpuWr: begin
                    if (cpu_oor_q) begin
                        if (state_q == StCpuRd) begin
                            cpu_rdata_q <= '0;
                        end
                        state_q   <= StCpuAck;
                        cpu_ack_q <= 1'b1;
                    end else if (mem_done) begin
                        if (state_q == StCpuRd) begin
                            cpu_rdata_q <= mem_din;
                        end
                        mem_rd_q  <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        state_q   <= StCpuAck;
                        cpu_ack_q <= 1'b1;
                    end
                end
                StVidRd: begin
                    if (mem_done) begin
                        mem_rd_q      <= 1'b0;
                        vid_busy_q    <= 1'b0;
                        vid_discard_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                StCpuAck: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase

            if (vid_start) begin
                vid_ptr_q     <= vid_base;
                vid_rem_q     <= vid_len;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                level_q       <= '0;
                underflow_q   <= 1'b0;
                vid_discard_q <= vid_busy_q && !mem_done;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr_q] <= push_data;
                    wr_ptr_q         <= wr_ptr_q + PtrW'(1);
                end
                if (pop_ok) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                if (vid_pop && level_q == '0) begin
                    underflow_q <= 1'b1;
                end
                if (push && !pop_ok) begin
                    level_q <= level_q + LvlW'(1);
                end else if (!push && pop_ok) begin
                    level_q <= level_q - LvlW'(1);
                end
            end
        end
    end

    assign cpu_rdata     = cpu_rdata_q;
    assign cpu_ack       = cpu_ack_q;
    assign vid_data      = fifo_q[rd_ptr_q];
    assign vid_empty     = (level_q == '0);
    assign vid_done      = (vid_rem_q == '0) && !vid_live;
    assign vid_underflow = underflow_q;
    assign mem_addr      = {7'd0, mem_addr_q};
    assign mem_dout      = mem_dout_q;
    assign mem_rd        = mem_rd_q;
    assign mem_wr        = mem_wr_q;
endmodule
